arcade_input_mux: RTL and testbench

- Parametrised player-input front end for System-1-class cores.
- Merges PS/2 keyboard, N MiSTer joysticks and cabinet mode into active-low per-player bytes and one system byte.
- Adds coin pulse stretching with frame-timed gaps and a queued coin.
- Sits between hps_io/LLAPI joystick merge and the game core INP ports.

---
 rtl/arcade_input_mux_if.sv | 22 ++
 rtl/arcade_input_mux.sv | 246 ++++++++++++++++++++++++
 tb/tb_arcade_input_mux.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_mux_if.sv
// rtl/arcade_input_mux_if.sv - player input bundle between joystick merge and game core
interface arcade_input_mux_if #(
    parameter int NPLAYERS = 2
);
    logic [10:0]             ps2_key;
    logic [NPLAYERS*16-1:0]  joy;
    logic                    vblank;
    logic                    cabinet;
    logic [NPLAYERS*8-1:0]   out_play;
    logic [7:0]              out_sys;
    logic                    coin_busy;

    modport master (
        output ps2_key, joy, vblank, cabinet,
        input  out_play, out_sys, coin_busy
    );

    modport slave (
        input  ps2_key, joy, vblank, cabinet,
        output out_play, out_sys, coin_busy
    );
endinterface

// File: rtl/arcade_input_mux.sv
// rtl/arcade_input_mux.sv - keyboard/joystick/cabinet merge into active-low INP bytes with coin stretchers
// Optional neutral SOCD cleaning when SOCD_CLEAN_EN is defined.
module arcade_input_mux #(
    parameter int NPLAYERS    = 2,
    parameter int COIN_FRAMES = 3,
    parameter int COIN_MERGE  = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    arcade_input_mux_if.slave bus
);

    localparam int NS    = (COIN_MERGE != 0) ? 1 : 2;
    localparam int CW    = $clog2(COIN_FRAMES + 1);
    localparam int NK    = 18;
    localparam int P2IDX = (NPLAYERS >= 2) ? 1 : 0;

    // Key latch layout: per player R,L,D,U,B1,B2 matches joystick bits 0..5
    localparam int K_P1R = 0,  K_P1L = 1,  K_P1D = 2,  K_P1U = 3,  K_P1B1 = 4,  K_P1B2 = 5;
    localparam int K_P2R = 6,  K_P2L = 7,  K_P2D = 8,  K_P2U = 9,  K_P2B1 = 10, K_P2B2 = 11;
    localparam int K_S1  = 12, K_S2  = 13, K_C1  = 14, K_C2  = 15, K_F1   = 16, K_F2   = 17;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } coin_state_e;

    logic           prime_q;
    logic           tog_q;
    logic [NK-1:0]  key_q;
    logic [NK-1:0]  key_d;
    logic [NK-1:0]  key_hit;
    logic           key_evt;

    assign key_evt = prime_q && (bus.ps2_key[10] != tog_q);
    assign key_d   = (key_q & ~key_hit) | (key_hit & {NK{bus.ps2_key[9]}});

    always_comb begin
        key_hit = '0;
        case (bus.ps2_key[7:0])
            8'h74:   key_hit[K_P1R]  = bus.ps2_key[8];
            8'h6B:   key_hit[K_P1L]  = bus.ps2_key[8];
            8'h72:   key_hit[K_P1D]  = bus.ps2_key[8];
            8'h75:   key_hit[K_P1U]  = bus.ps2_key[8];
            8'h29:   key_hit[K_P1B1] = 1'b1;
            8'h14:   key_hit[K_P1B2] = 1'b1;
            8'h34:   key_hit[K_P2R]  = 1'b1;
            8'h23:   key_hit[K_P2L]  = 1'b1;
            8'h2B:   key_hit[K_P2D]  = 1'b1;
            8'h2D:   key_hit[K_P2U]  = 1'b1;
            8'h1C:   key_hit[K_P2B1] = 1'b1;
            8'h1B:   key_hit[K_P2B2] = 1'b1;
            8'h16:   key_hit[K_S1]   = 1'b1;
            8'h1E:   key_hit[K_S2]   = 1'b1;
            8'h2E:   key_hit[K_C1]   = 1'b1;
            8'h36:   key_hit[K_C2]   = 1'b1;
            8'h05:   key_hit[K_F1]   = 1'b1;
            8'h06:   key_hit[K_F2]   = 1'b1;
            default: key_hit = '0;
        endcase
    end

    // The first cycle after reset only samples the strobe, so a stale level never counts as an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prime_q <= 1'b0;
            tog_q   <= 1'b0;
            key_q   <= '0;
        end else if (!prime_q) begin
            prime_q <= 1'b1;
            tog_q   <= bus.ps2_key[10];
        end else if (key_evt) begin
            tog_q   <= bus.ps2_key[10];
            key_q   <= key_d;
        end
    end

    logic [5:0]             raw [NPLAYERS];
    logic [5:0]             ctl [NPLAYERS];
    logic [NPLAYERS*8-1:0]  play_d;

    always_comb begin
        for (int p = 0; p < NPLAYERS; p++) begin
            raw[p] = bus.joy[p*16 +: 6];
            if (p == 0)
                raw[p] = raw[p] | key_q[5:0];
            else if (p == 1)
                raw[p] = raw[p] | key_q[11:6];
        end
        for (int p = 0; p < NPLAYERS; p++)
            ctl[p] = raw[p];
        // Upright cabinets share one control panel, so P2 inputs also drive P1.
        if (NPLAYERS >= 2 && !bus.cabinet)
            ctl[0] = raw[0] | raw[P2IDX];
        play_d = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
`ifdef SOCD_CLEAN_EN
            if (ctl[p][0] && ctl[p][1])
                ctl[p][1:0] = 2'b00;
            if (ctl[p][2] && ctl[p][3])
                ctl[p][3:2] = 2'b00;
`endif
            play_d[p*8 +: 8] = ~{ctl[p][1], ctl[p][0], ctl[p][3], ctl[p][2],
                                 1'b0, ctl[p][5], ctl[p][4], 1'b0};
        end
    end

    logic [1:0] start_d;
    logic       creq1;
    logic       creq2;

    always_comb begin
        start_d = {key_q[K_S2] | key_q[K_F2], key_q[K_S1] | key_q[K_F1]};
        creq1   = key_q[K_C1] | key_q[K_F1] | bus.joy[8];
        creq2   = key_q[K_C2] | key_q[K_F2];
        for (int p = 0; p < NPLAYERS; p++) begin
            start_d[0] = start_d[0] | bus.joy[p*16 + 6];
            start_d[1] = start_d[1] | bus.joy[p*16 + 7];
            if (p >= 1)
                creq2 = creq2 | bus.joy[p*16 + 8];
        end
    end

    logic [NPLAYERS*8-1:0]  out_play_q;
    logic [1:0]             start_q;
    logic                   vb_q;
    logic                   vb_rise;

    assign vb_rise = bus.vblank & ~vb_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            out_play_q <= '1;
            start_q    <= '0;
            vb_q       <= 1'b0;
        end else begin
            out_play_q <= play_d;
            start_q    <= start_d;
            vb_q       <= bus.vblank;
        end
    end

    logic [NS-1:0] creq;
    logic [NS-1:0] coin_act;
    logic [NS-1:0] coin_bsy;

    generate
        if (NS == 1) begin : g_merge
            assign creq = creq1 | creq2;
        end else begin : g_split
            assign creq = {creq2, creq1};
        end
    endgenerate

    for (genvar s = 0; s < NS; s++) begin : g_coin
        coin_state_e    state_q;
        logic [CW-1:0]  cnt_q;
        logic [CW-1:0]  cnt_inc;
        logic           pend_q;
        logic           req_q;
        logic           act_q;
        logic           busy_q;
        logic           req_rise;

        assign req_rise = creq[s] & ~req_q;
        assign cnt_inc  = cnt_q + 1'b1;

        // A request edge arriving with the closing vblank of GAP is served as the queued coin.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                req_q   <= 1'b0;
                act_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                req_q <= creq[s];
                case (state_q)
                    S_IDLE: begin
                        if (req_rise) begin
                            state_q <= S_ACTIVE;
                            cnt_q   <= '0;
                            act_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_ACTIVE: begin
                        if (req_rise)
                            pend_q <= 1'b1;
                        if (vb_rise) begin
                            if (cnt_inc == CW'(COIN_FRAMES)) begin
                                state_q <= S_GAP;
                                cnt_q   <= '0;
                                act_q   <= 1'b0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end
                    S_GAP: begin
                        if (req_rise)
                            pend_q <= 1'b1;
                        if (vb_rise) begin
                            if (cnt_inc == CW'(COIN_FRAMES)) begin
                                cnt_q <= '0;
                                if (pend_q || req_rise) begin
                                    state_q <= S_ACTIVE;
                                    pend_q  <= 1'b0;
                                    act_q   <= 1'b1;
                                end else begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        act_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign coin_act[s] = act_q;
        assign coin_bsy[s] = busy_q;
    end

    logic coin1_n;
    logic coin2_n;
    logic unused_joy;

    assign coin1_n    = ~coin_act[0];
    assign coin2_n    = (NS == 2) ? ~coin_act[NS-1] : 1'b1;
    assign unused_joy = ^bus.joy;

    assign bus.out_play  = out_play_q;
    assign bus.out_sys   = {2'b11, ~start_q[1], ~start_q[0], 2'b11, coin2_n, coin1_n};
    assign bus.coin_busy = |coin_bsy;

endmodule

// File: tb/tb_arcade_input_mux.sv
// tb/tb_arcade_input_mux.sv - randomized self-checking bench for arcade_input_mux
module tb_arcade_input_mux;

    localparam int NP = 2;
    localparam int CF = 3;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    arcade_input_mux_if #(.NPLAYERS(NP)) bus();

    arcade_input_mux #(.NPLAYERS(NP), .COIN_FRAMES(CF), .COIN_MERGE(1)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          kp [18];
    bit          tog;
    logic [31:0] joyv;
    bit          cab;

    logic [7:0] codes [22] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h2D, 8'h2B,
                               8'h23, 8'h34, 8'h1C, 8'h1B, 8'h16, 8'h1E, 8'h2E, 8'h36,
                               8'h05, 8'h06, 8'h1D, 8'h5A, 8'h00, 8'hE0};

    function automatic int key_id(input bit ext, input logic [7:0] code);
        case (code)
            8'h74: return ext ? 0 : -1;
            8'h6B: return ext ? 1 : -1;
            8'h72: return ext ? 2 : -1;
            8'h75: return ext ? 3 : -1;
            8'h29: return 4;
            8'h14: return 5;
            8'h34: return 6;
            8'h23: return 7;
            8'h2B: return 8;
            8'h2D: return 9;
            8'h1C: return 10;
            8'h1B: return 11;
            8'h16: return 12;
            8'h1E: return 13;
            8'h2E: return 14;
            8'h36: return 15;
            8'h05: return 16;
            8'h06: return 17;
            default: return -1;
        endcase
    endfunction

    function automatic logic [15:0] exp_play();
        bit up [2], dn [2], lf [2], rt [2], b1 [2], b2 [2];
        logic [15:0] r;
        for (int p = 0; p < 2; p++) begin
            rt[p] = kp[p*6+0] | joyv[p*16+0];
            lf[p] = kp[p*6+1] | joyv[p*16+1];
            dn[p] = kp[p*6+2] | joyv[p*16+2];
            up[p] = kp[p*6+3] | joyv[p*16+3];
            b1[p] = kp[p*6+4] | joyv[p*16+4];
            b2[p] = kp[p*6+5] | joyv[p*16+5];
        end
        if (!cab) begin
            rt[0] |= rt[1]; lf[0] |= lf[1]; dn[0] |= dn[1];
            up[0] |= up[1]; b1[0] |= b1[1]; b2[0] |= b2[1];
        end
        for (int p = 0; p < 2; p++) begin
`ifdef SOCD_CLEAN_EN
            if (lf[p] && rt[p]) begin lf[p] = 0; rt[p] = 0; end
            if (up[p] && dn[p]) begin up[p] = 0; dn[p] = 0; end
`endif
            r[p*8 +: 8] = {~lf[p], ~rt[p], ~up[p], ~dn[p], 1'b1, ~b2[p], ~b1[p], 1'b1};
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_start();
        bit s1, s2;
        s1 = kp[12] | kp[16] | joyv[6] | joyv[22];
        s2 = kp[13] | kp[17] | joyv[7] | joyv[23];
        return {~s2, ~s1};
    endfunction

    task automatic apply();
        bus.joy     = joyv;
        bus.cabinet = cab;
    endtask

    task automatic send_key(input bit pressed, input bit ext, input logic [7:0] code);
        int id;
        @(negedge clk_sys);
        tog = ~tog;
        bus.ps2_key = {tog, pressed, ext, code};
        id = key_id(ext, code);
        if (id >= 0) kp[id] = pressed;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic vblank_pulse();
        @(negedge clk_sys);
        bus.vblank = 1'b1;
        @(negedge clk_sys);
        bus.vblank = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        tog = 1'b1;
        bus.ps2_key = 11'h400;
        joyv = '0; cab = 1'b1; apply();
        bus.vblank = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_checks++; if (bus.out_play !== 16'hFFFF) begin n_fail++; $display("FAIL reset_play: got %h expected ffff", bus.out_play); end
        n_checks++; if (bus.out_sys !== 8'hFF) begin n_fail++; $display("FAIL reset_sys: got %h expected ff", bus.out_sys); end
        n_checks++; if (bus.coin_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.coin_busy); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        n_checks++; if (bus.out_play !== 16'hFFFF) begin n_fail++; $display("FAIL idle_play: got %h expected ffff", bus.out_play); end
        n_checks++; if (bus.out_sys !== 8'hFF) begin n_fail++; $display("FAIL idle_sys: got %h expected ff", bus.out_sys); end
    endtask

    task automatic test_key_latency();
        @(negedge clk_sys);
        tog = ~tog;
        bus.ps2_key = {tog, 1'b1, 1'b1, 8'h75};
        kp[3] = 1'b1;
        @(negedge clk_sys);
        n_checks++; if (bus.out_play[5] !== 1'b1) begin n_fail++; $display("FAIL key_lat1: got %b expected 1", bus.out_play[5]); end
        @(negedge clk_sys);
        n_checks++; if (bus.out_play[5] !== 1'b0) begin n_fail++; $display("FAIL key_lat2: got %b expected 0", bus.out_play[5]); end
        send_key(1'b0, 1'b1, 8'h75);
        n_checks++; if (bus.out_play[5] !== 1'b1) begin n_fail++; $display("FAIL key_release: got %b expected 1", bus.out_play[5]); end
    endtask

    task automatic test_keyboard_random();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] c;
            bit e, pr;
            c  = codes[$urandom_range(0, 21)];
            e  = ($urandom_range(0, 3) != 0);
            pr = $urandom_range(0, 1);
            if (i % 8 == 7) cab = ~cab;
            apply();
            send_key(pr, e, c);
            n_checks++; if (bus.out_play !== exp_play()) begin n_fail++; $display("FAIL kbd_play[%0d]: got %h expected %h", i, bus.out_play, exp_play()); end
            n_checks++; if (bus.out_sys[5:4] !== exp_start()) begin n_fail++; $display("FAIL kbd_start[%0d]: got %b expected %b", i, bus.out_sys[5:4], exp_start()); end
        end
        for (int i = 0; i < 18; i++) send_key(1'b0, 1'b1, codes[i]);
        n_checks++; if (bus.out_play !== 16'hFFFF) begin n_fail++; $display("FAIL kbd_clear: got %h expected ffff", bus.out_play); end
    endtask

    task automatic test_joy_random();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_sys);
            joyv = $urandom & 32'h00FF_00FF;
            cab  = $urandom_range(0, 1);
            apply();
            @(negedge clk_sys);
            n_checks++; if (bus.out_play !== exp_play()) begin n_fail++; $display("FAIL joy_play[%0d]: got %h expected %h", i, bus.out_play, exp_play()); end
            n_checks++; if (bus.out_sys[5:4] !== exp_start()) begin n_fail++; $display("FAIL joy_start[%0d]: got %b expected %b", i, bus.out_sys[5:4], exp_start()); end
        end
    endtask

    task automatic test_cabinet();
        @(negedge clk_sys);
        joyv = 32'h0010_0000; cab = 1'b0; apply();
        @(negedge clk_sys);
        n_checks++; if ({bus.out_play[9], bus.out_play[1]} !== 2'b00) begin n_fail++; $display("FAIL cab_upright: got %b expected 00", {bus.out_play[9], bus.out_play[1]}); end
        cab = 1'b1; apply();
        @(negedge clk_sys);
        n_checks++; if ({bus.out_play[9], bus.out_play[1]} !== 2'b01) begin n_fail++; $display("FAIL cab_cocktail: got %b expected 01", {bus.out_play[9], bus.out_play[1]}); end
    endtask

    task automatic test_socd();
        logic [3:0] want;
`ifdef SOCD_CLEAN_EN
        want = 4'b1101;
`else
        want = 4'b0001;
`endif
        @(negedge clk_sys);
        joyv = 32'h0000_000B; cab = 1'b1; apply();
        @(negedge clk_sys);
        n_checks++; if (bus.out_play[7:4] !== want) begin n_fail++; $display("FAIL socd: got %b expected %b", bus.out_play[7:4], want); end
        joyv = '0; apply();
        @(negedge clk_sys);
    endtask

    task automatic drain_coin(input string tag);
        int guard = 0;
        while (bus.coin_busy === 1'b1 && guard < 20) begin
            vblank_pulse();
            guard++;
        end
        n_checks++; if (bus.coin_busy !== 1'b0) begin n_fail++; $display("FAIL drain_%s: got busy %b expected 0", tag, bus.coin_busy); end
    endtask

    // Frame-level schedule: each pulse owns CF active then CF gap frames, one extra pulse may wait.
    task automatic coin_scenario(input logic [63:0] evmask, input int nf, input string tag);
        bit exp_on [64];
        bit exp_bsy [64];
        int last_start = -1000;
        int busy_end   = 0;
        for (int f = 0; f < 64; f++) begin exp_on[f] = 0; exp_bsy[f] = 0; end
        for (int f = 0; f < nf; f++) begin
            if (evmask[f]) begin
                int st = -1;
                if (f >= busy_end) begin st = f; last_start = f; busy_end = f + 2*CF; end
                else if (f >= last_start) begin st = busy_end; last_start = busy_end; busy_end += 2*CF; end
                if (st >= 0)
                    for (int k = st; k < st + CF && k < 64; k++) exp_on[k] = 1;
            end
            exp_bsy[f] = (f < busy_end);
        end
        for (int f = 0; f < nf; f++) begin
            if (evmask[f]) begin
                int bitpos = ($urandom_range(0, 1) != 0) ? 24 : 8;
                @(negedge clk_sys);
                joyv[bitpos] = 1'b1; apply();
                @(negedge clk_sys);
                joyv[bitpos] = 1'b0; apply();
            end
            @(negedge clk_sys);
            @(negedge clk_sys);
            n_checks++; if (bus.out_sys[0] !== ~exp_on[f]) begin n_fail++; $display("FAIL coin_%s[%0d]: got %b expected %b", tag, f, bus.out_sys[0], ~exp_on[f]); end
            n_checks++; if (bus.coin_busy !== exp_bsy[f]) begin n_fail++; $display("FAIL busy_%s[%0d]: got %b expected %b", tag, f, bus.coin_busy, exp_bsy[f]); end
            vblank_pulse();
        end
        drain_coin(tag);
    endtask

    task automatic test_coin();
        logic [63:0] m;
        joyv = '0; cab = 1'b1; apply();
        drain_coin("pre");
        coin_scenario(64'h1, 8, "single");
        coin_scenario(64'h17, 14, "queue");
        m = '0;
        for (int f = 0; f < 40; f++) m[f] = ($urandom_range(0, 3) == 0);
        coin_scenario(m, 40, "rand");
    endtask

    task automatic test_reset_mid();
        @(negedge clk_sys);
        joyv[8] = 1'b1; apply();
        @(negedge clk_sys);
        joyv[8] = 1'b0; apply();
        send_key(1'b1, 1'b1, 8'h75);
        n_checks++; if (bus.coin_busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy: got %b expected 1", bus.coin_busy); end
        n_checks++; if (bus.out_play !== exp_play()) begin n_fail++; $display("FAIL mid_pre_play: got %h expected %h", bus.out_play, exp_play()); end
        #2 reset_n = 1'b0;
        for (int i = 0; i < 18; i++) kp[i] = 0;
        #1;
        n_checks++; if (bus.out_play !== 16'hFFFF) begin n_fail++; $display("FAIL mid_async_play: got %h expected ffff", bus.out_play); end
        n_checks++; if (bus.out_sys !== 8'hFF) begin n_fail++; $display("FAIL mid_async_sys: got %h expected ff", bus.out_sys); end
        n_checks++; if (bus.coin_busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy: got %b expected 0", bus.coin_busy); end
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        n_checks++; if (bus.out_play !== 16'hFFFF) begin n_fail++; $display("FAIL mid_noreplay: got %h expected ffff", bus.out_play); end
        n_checks++; if (bus.coin_busy !== 1'b0) begin n_fail++; $display("FAIL mid_post_busy: got %b expected 0", bus.coin_busy); end
        send_key(1'b1, 1'b0, 8'h29);
        n_checks++; if (bus.out_play !== exp_play()) begin n_fail++; $display("FAIL mid_newkey: got %h expected %h", bus.out_play, exp_play()); end
        send_key(1'b0, 1'b0, 8'h29);
    endtask

    initial begin
        for (int i = 0; i < 18; i++) kp[i] = 0;
        test_reset();
        test_key_latency();
        test_keyboard_random();
        test_joy_random();
        test_cabinet();
        test_socd();
        test_coin();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
